// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants and feeder state encoding for the UART transmit path.
// BPS_* are clocks per bit at a 50 MHz system clock.
package uart_tx_feeder_pkg;
   localparam int BPS_50MHz_115200 = 434;
   localparam int BPS_50MHz_9600   = 5208;
   localparam int FRAME_BITS       = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } feed_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with wrap-bit pointers.
// The read port is combinational, and full writes set a sticky overflow flag.
module sync_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);
   logic [7:0]      mem [2**ADDR_W];
   logic [ADDR_W:0] wr_ptr, rd_ptr;
   logic            do_wr, do_rd;

   // Full means the pointers are equal in address bits but differ in wrap bits.
   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && full) overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds the UART transmitter one byte per frame from a small FIFO.
// The enable is held until tx_done, followed by an optional idle gap.
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int          ADDR_W  = 4,
   parameter logic [15:0] GAP_CLK = 16'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              busy,
   output logic              tx_en_sig,
   output logic [7:0]        tx_data,
   input  logic              tx_done
);
   feed_state_e state;
   logic [15:0] gap_cnt;
   logic [7:0]  rd_data;
   logic        rd_en;

   // Pop happens on the same edge that latches the byte into tx_data.
   assign rd_en = (state == IDLE) && !empty;
   assign busy  = (state != IDLE);

   sync_fifo #(.ADDR_W(ADDR_W)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         tx_en_sig <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         case (state)
            IDLE: if (!empty) begin
               tx_data   <= rd_data;
               tx_en_sig <= 1'b1;
               state     <= SEND;
            end
            // Drop the enable only on tx_done; the transmitter would otherwise resume mid-frame.
            SEND: if (tx_done) begin
               tx_en_sig <= 1'b0;
               if (GAP_CLK != 16'd0) begin
                  gap_cnt <= GAP_CLK - 16'd1;
                  state   <= GAP;
               end else begin
                  state <= IDLE;
               end
            end
            GAP: if (gap_cnt == 16'd0) state <= IDLE;
                 else gap_cnt <= gap_cnt - 16'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder, using a behavioural transmitter for the main instance.
// A second instance with GAP_CLK=5 is driven by hand.
module tb_uart_tx_feeder;
   import uart_tx_feeder_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, overflow, busy, tx_en_sig, tx_done;
   logic [4:0] count;
   logic [7:0] tx_data;

   logic       wr_en_g = 1'b0;
   logic [7:0] wr_data_g = 8'h00;
   logic       done_g = 1'b0;
   logic       full_g, empty_g, overflow_g, busy_g, en_g;
   logic [4:0] count_g;
   logic [7:0] data_g;

   int   n_chk = 0, n_fail = 0;
   int   bps = BPS_50MHz_115200;
   logic stall = 1'b0, inj_done = 1'b0, m_done, tx_pin;
   int   m_cnt, m_bit;

   logic [7:0] got_q [$];
   int         low_q [$];
   int         low_cnt = 0;
   logic       prev_en = 1'b0, started = 1'b0;

   always #5 clk = ~clk;

   uart_tx_feeder #(.ADDR_W(4), .GAP_CLK(16'd0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .busy(busy), .tx_en_sig(tx_en_sig), .tx_data(tx_data), .tx_done(tx_done)
   );

   uart_tx_feeder #(.ADDR_W(4), .GAP_CLK(16'd5)) u_gap (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en_g), .wr_data(wr_data_g),
      .full(full_g), .empty(empty_g), .count(count_g), .overflow(overflow_g),
      .busy(busy_g), .tx_en_sig(en_g), .tx_data(data_g), .tx_done(done_g)
   );

   // Transmitter model: runs 10 bits of bps clocks, then pulses done and clears its own state.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_bit <= 0; m_done <= 1'b0;
      end else if (m_done) begin
         m_cnt <= 0; m_bit <= 0; m_done <= 1'b0;
      end else if (tx_en_sig) begin
         if (m_cnt == bps - 1) begin
            if (m_bit == FRAME_BITS - 1) begin
               if (!stall) m_done <= 1'b1;
            end else begin
               m_cnt <= 0; m_bit <= m_bit + 1;
            end
         end else m_cnt <= m_cnt + 1;
      end
   end
   assign tx_done = m_done | inj_done;

   always_comb begin
      tx_pin = 1'b1;
      if (tx_en_sig) begin
         if (m_bit == 0) tx_pin = 1'b0;
         else if (m_bit < FRAME_BITS - 1) tx_pin = tx_data[m_bit-1];
      end
   end

   initial forever begin
      @(negedge clk);
      if (tx_en_sig && !prev_en) begin
         got_q.push_back(tx_data);
         if (started) low_q.push_back(low_cnt);
         started = 1'b1;
      end
      if (!tx_en_sig) low_cnt++;
      else low_cnt = 0;
      prev_en = tx_en_sig;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic mon_clr();
      got_q.delete(); low_q.delete(); started = 1'b0;
   endtask

   task automatic wait_drain(input int lim, input string tag);
      int i;
      for (i = 0; i < lim; i++) begin
         if (empty && !busy) break;
         tick();
      end
      chk(tag, 32'(i < lim), 32'd1);
   endtask

   task automatic put(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
   endtask

   initial begin
      logic [9:0] frame;
      int i, low, n_acc, err;

      // reset state
      repeat (3) tick();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_en", 32'(tx_en_sig), 0);
      chk("rst_data", 32'(tx_data), 0);
      rst_n = 1'b1; tick();

      // stray tx_done in IDLE
      inj_done = 1'b1; tick(); inj_done = 1'b0; tick();
      chk("idle_done_busy", 32'(busy), 0);
      chk("idle_done_en", 32'(tx_en_sig), 0);

      // single byte at 115200
      mon_clr();
      put(8'hA5);
      chk("single_cnt1", 32'(count), 1);
      chk("single_en_wr", 32'(tx_en_sig), 0);
      tick();
      chk("single_en", 32'(tx_en_sig), 1);
      chk("single_cnt0", 32'(count), 0);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < FRAME_BITS; k++) begin
         repeat (k == 0 ? bps / 2 : bps) tick();
         chk($sformatf("single_pin%0d", k), 32'(tx_pin), 32'(frame[k]));
         chk($sformatf("single_data%0d", k), 32'(tx_data), 32'hA5);
      end
      for (i = 0; i < 1000 && tx_en_sig; i++) tick();
      chk("single_fall", 32'(tx_en_sig), 0);
      chk("single_empty", 32'(empty), 1);
      chk("single_busy", 32'(busy), 0);
      chk("single_nframes", 32'(got_q.size()), 1);

      // burst of five with GAP_CLK=0
      bps = 4; mon_clr();
      wr_en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wr_data = 8'(k); tick();
      end
      wr_en = 1'b0;
      chk("burst_peak", 32'(count), 4);
      wait_drain(1000, "burst_drain");
      tick();
      chk("burst_nframes", 32'(got_q.size()), 5);
      for (int k = 0; k < 5 && k < got_q.size(); k++)
         chk($sformatf("burst_byte%0d", k), 32'(got_q[k]), 32'(k + 1));
      for (int k = 0; k < 4 && k < low_q.size(); k++)
         chk($sformatf("burst_low%0d", k), 32'(low_q[k]), 1);

      // full / overflow with the transmitter stalled
      stall = 1'b1; mon_clr();
      wr_en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         wr_data = 8'h80 + 8'(k); tick();
      end
      chk("full_cnt", 32'(count), 16);
      chk("full_flag", 32'(full), 1);
      chk("full_ovf0", 32'(overflow), 0);
      wr_data = 8'hEE; tick(); wr_en = 1'b0;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_cnt", 32'(count), 16);
      stall = 1'b0;
      wait_drain(3000, "ovf_drain");
      tick();
      chk("ovf_sticky", 32'(overflow), 1);
      chk("ovf_nframes", 32'(got_q.size()), 17);
      err = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] != 8'h80 + 8'(k)) err++;
      chk("ovf_order", 32'(err), 0);

      // pointer wrap with random write spacing
      bps = 2; mon_clr();
      n_acc = 0; err = 0;
      for (i = 0; i < 6000; i++) begin
         wr_en = (n_acc < 40) && !full && ($urandom_range(0, 3) == 0);
         wr_data = 8'h40 + 8'(n_acc);
         if (wr_en) n_acc++;
         @(negedge clk); #1;
         wr_en = 1'b0;
         if (32'(count) != 32'(n_acc - got_q.size())) err++;
         if (n_acc == 40 && empty && !busy) break;
      end
      chk("wrap_done", 32'(i < 6000), 1);
      chk("wrap_cnt_err", 32'(err), 0);
      chk("wrap_nframes", 32'(got_q.size()), 40);
      err = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] != 8'h40 + 8'(k)) err++;
      chk("wrap_order", 32'(err), 0);

      // gap instance: GAP_CLK=5 gives six low cycles
      wr_en_g = 1'b1; wr_data_g = 8'h11; tick();
      wr_data_g = 8'h22; tick(); wr_en_g = 1'b0;
      chk("gap_en1", 32'(en_g), 1);
      chk("gap_data1", 32'(data_g), 32'h11);
      repeat (3) tick();
      done_g = 1'b1; tick(); done_g = 1'b0;
      chk("gap_fall", 32'(en_g), 0);
      chk("gap_busy", 32'(busy_g), 1);
      low = 1;
      for (i = 0; i < 40; i++) begin
         done_g = (low == 2);
         tick();
         done_g = 1'b0;
         if (en_g) break;
         low++;
      end
      chk("gap_low", 32'(low), 6);
      chk("gap_data2", 32'(data_g), 32'h22);
      tick(); done_g = 1'b1; tick(); done_g = 1'b0;
      repeat (8) tick();
      chk("gap_idle", 32'(busy_g), 0);
      chk("gap_empty", 32'(empty_g), 1);
      chk("gap_cnt", 32'(count_g), 0);
      chk("gap_full", 32'(full_g), 0);
      chk("gap_ovf", 32'(overflow_g), 0);

      // reset mid-frame, overflow is still set from earlier
      bps = BPS_50MHz_115200;
      wr_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_data = 8'hC0 + 8'(k); tick();
      end
      wr_en = 1'b0;
      repeat (2000) tick();
      chk("mid_en_pre", 32'(tx_en_sig), 1);
      chk("mid_cnt_pre", 32'(count), 3);
      rst_n = 1'b0; #1;
      chk("mid_en", 32'(tx_en_sig), 0);
      chk("mid_cnt", 32'(count), 0);
      chk("mid_ovf", 32'(overflow), 0);
      tick(); rst_n = 1'b1;
      repeat (50) tick();
      chk("mid_noframe", 32'(tx_en_sig), 0);
      chk("mid_busy", 32'(busy), 0);
      put(8'h5A); tick();
      chk("mid_new_en", 32'(tx_en_sig), 1);
      chk("mid_new_data", 32'(tx_data), 32'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte-buffering sequencer upstream of the UART transmit stage.
- Accepts bytes from a system-side write port into a small synchronous FIFO.
- Presents one byte at a time to the transmitter on tx_en_sig/tx_data and holds the enable for the whole frame.
- Releases the enable on the transmitter's one-cycle tx_done pulse, optionally inserts an idle gap, then moves to the next byte.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.
- GAP_CLK, 16'd0, idle clocks inserted between frames after tx_done; 0 = back-to-back.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; one byte written per cycle it is high.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds 2**ADDR_W bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  output  1  sticky; a write was dropped because the FIFO was full.
- busy  output  1  high whenever the state is not IDLE.
- tx_en_sig  output  1  enable to the transmitter; held high for the entire frame.
- tx_data  output  8  byte being transmitted; stable while tx_en_sig is high.
- tx_done  input  1  one-cycle completion pulse from the transmitter.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - count=0, empty=1, full=0, overflow=0, busy=0, tx_en_sig=0, tx_data=8'h00.
  - Read/write pointers = 0; gap counter = 0; state = IDLE.
  - FIFO memory contents are not reset.
- FIFO:
  - Circular pointers of ADDR_W+1 bits. full/empty/count are derived from the pointers.
  - Write accepted when wr_en=1 and full=0 (full as sampled before the edge).
  - When wr_en=1 and full=1, the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge.
  - overflow clears only on reset.
  - A write and a pop on the same edge leave count unchanged. Pointers wrap from 2**ADDR_W-1 to 0.
- States:
  - IDLE: if empty=0, then at the next edge tx_data <= mem[rd_ptr], rd_ptr += 1, tx_en_sig <= 1, go to SEND. Otherwise stay in IDLE.
  - SEND:
    - tx_en_sig and tx_data are held.
    - On an edge where tx_done=1: tx_en_sig <= 0.
    - Then go to GAP if GAP_CLK != 0 (load the gap counter with GAP_CLK-1), else go to IDLE.
    - Because tx_en_sig drops on the same edge the transmitter clears tx_done, the transmitter never begins a second frame on stale data.
  - GAP: decrement the counter; when it reaches 0, go to IDLE. tx_en_sig stays 0.
- Latency and throughput:
  - A write sampled on edge N into an empty, idle block raises tx_en_sig after edge N+1.
  - With GAP_CLK=0, the next tx_en_sig rises 2 cycles after the edge that ended the previous frame (1 cycle low in IDLE).
- tx_en_sig is never deasserted mid-frame. The transmitter does not reset its counters on a dropped enable, so this is mandatory.
- tx_done seen while in IDLE or GAP is ignored.
- Reset mid-frame: all state returns to reset values; the transmitter is reset by the same rst_n.

Decomposition:
- Shared uart package: constants BPS_50MHz_115200=434 and BPS_50MHz_9600=5208, frame length of 10 bits, and the state encoding IDLE/SEND/GAP.
- One natural sub-module: sync_fifo (parameter ADDR_W, width 8). It provides wr_en/wr_data/rd_en/rd_data (asynchronous read at rd_ptr) and full/empty/count/overflow.
- The feeder FSM stays in the top-level block.

Test Plan:
- Single byte: write 8'hA5 into an idle block, paired with the transmitter at BPS=434 → tx_en_sig high 1 cycle after the write edge. tx_data=8'hA5 for the whole frame. tx_pin shows start bit, bits 1,0,1,0,0,1,0,1 (LSB first), then stop bit. tx_en_sig falls on the tx_done edge. empty=1, busy=0 afterwards.
- Burst: write 8'h01..8'h05 on consecutive cycles → five frames in order. count peaks at 4 (one byte is popped immediately). With GAP_CLK=0, exactly 1 idle cycle of tx_en_sig low between frames.
- Full/overflow: hold the transmitter's tx_done low and write 18 bytes → count=16 and full=1 after 17 writes (one byte is in SEND). The 18th write is dropped and overflow=1. Overflow stays 1 after the FIFO drains.
- Pointer wrap: over time, write and transmit 40 bytes with mixed simultaneous write/pop edges → output order equals input order. count is never off by one on simultaneous edges.
- Gap: GAP_CLK=5, two queued bytes → tx_en_sig low for exactly 6 cycles between frames (5 GAP + 1 IDLE).
- Reset mid-frame: assert rst_n=0 at cycle 2000 of a frame with 3 bytes queued → tx_en_sig=0, count=0, overflow=0 immediately. No frame starts after release until a new write.
